// File: rtl/bus_pkg.sv
// Shared sizing and index types for the one-to-four bus demultiplexer.
package bus_pkg;

   localparam int DATA_W = 8;
   localparam int N_DEST = 4;

   typedef logic [1:0] dest_t;

endpackage

// File: rtl/demux_slot.sv
// One destination of the demultiplexer: holding register plus valid flag.
module demux_slot #(
   parameter int DATA_W = bus_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              ack,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              free
);

   // A slot being drained this cycle can take a new byte with no bubble.
   assign free = !valid || ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (wr) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (ack) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/bus_demux.sv
// Routes one source byte to one or all of four held destination registers.
module bus_demux #(
   parameter int DATA_W = bus_pkg::DATA_W,
   parameter int N_DEST = bus_pkg::N_DEST
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     din,
   input  bus_pkg::dest_t        sel,
   input  logic                  bcast,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     dout0,
   output logic [DATA_W-1:0]     dout1,
   output logic [DATA_W-1:0]     dout2,
   output logic [DATA_W-1:0]     dout3,
   output logic [N_DEST-1:0]     out_valid,
   input  logic [N_DEST-1:0]     out_ack,
   output logic [7:0]            xfer_count
);

   logic [N_DEST-1:0] free;
   logic [N_DEST-1:0] hit;
   logic [N_DEST-1:0] wr;
   logic [DATA_W-1:0] dq [N_DEST];
   logic              accept;

   always_comb begin
      hit = '0;
      for (int i = 0; i < N_DEST; i++) begin
         hit[i] = bcast || (sel == bus_pkg::dest_t'(i));
      end
   end

   // A broadcast waits until every slot can take the byte at once.
   assign in_ready = !reset && (bcast ? &free : free[sel]);
   assign accept   = in_valid && in_ready;
   assign wr       = accept ? hit : '0;

   for (genvar g = 0; g < N_DEST; g++) begin : g_slot
      demux_slot #(.DATA_W(DATA_W)) u_slot (
         .clk   (clk),
         .reset (reset),
         .wr    (wr[g]),
         .ack   (out_ack[g]),
         .din   (din),
         .dout  (dq[g]),
         .valid (out_valid[g]),
         .free  (free[g])
      );
   end

   assign dout0 = dq[0];
   assign dout1 = dq[1];
   assign dout2 = dq[2];
   assign dout3 = dq[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_count <= '0;
      end else if (accept) begin
         xfer_count <= xfer_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_bus_demux.sv
// Scoreboard bench for bus_demux: directed cases plus a randomised run.
module tb_bus_demux;
   import bus_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   dest_t      sel;
   logic       bcast;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dout0, dout1, dout2, dout3;
   logic [3:0] out_valid;
   logic [3:0] out_ack;
   logic [7:0] xfer_count;
   wire  [7:0] dv [4];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0] mask;
      logic [7:0] data;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   logic [3:0] mv;
   logic [7:0] md [4];
   logic [7:0] mc;
   logic       rdy_exp;
   logic       rdy_obs;
   logic       acc;

   always #5 clk = ~clk;

   bus_demux dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .sel        (sel),
      .bcast      (bcast),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dout0      (dout0),
      .dout1      (dout1),
      .dout2      (dout2),
      .dout3      (dout3),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .xfer_count (xfer_count)
   );

   assign dv[0] = dout0;
   assign dv[1] = dout1;
   assign dv[2] = dout2;
   assign dv[3] = dout3;

   function automatic logic model_ready();
      logic [3:0] f;
      f = ~mv | out_ack;
      if (reset) return 1'b0;
      return bcast ? &f : f[sel];
   endfunction

   // Drives one cycle, predicts acceptance, advances the reference model.
   task automatic drive(input logic [7:0] d, input logic [1:0] s,
                        input logic b, input logic v,
                        input logic [3:0] a, input logic r);
      exp_t x;
      @(negedge clk);
      din = d; sel = s; bcast = b; in_valid = v; out_ack = a; reset = r;
      #1;
      rdy_exp = model_ready();
      rdy_obs = in_ready;
      acc = v && rdy_exp;
      if (acc) begin
         x.mask = b ? 4'hF : 4'(1 << s);
         x.data = d;
         x.cnt  = mc + 8'd1;
         sb.push_back(x);
      end
      @(posedge clk);
      if (r) begin
         mv = '0;
         md = '{default: 8'h00};
         mc = '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (acc && (b || int'(s) == i)) begin
               md[i] = d;
               mv[i] = 1'b1;
            end else if (a[i]) begin
               mv[i] = 1'b0;
            end
         end
         if (acc) mc = mc + 8'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
      drive(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
      n_tests++;
      if (out_valid !== 4'b0000 || xfer_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: out_valid=%b count=%0d, want 0000/0",
                  out_valid, xfer_count);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (dv[i] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout%0d: got %h want 00", i, dv[i]);
         end
      end
      drive(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b want 1", rdy_obs);
      end
   endtask

   task automatic test_single();
      drive(8'hA5, 2'd2, 1'b0, 1'b1, 4'h0, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b1 || sb.size() != 1) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 1", rdy_obs);
      end else begin
         e = sb.pop_front();
         if (dout2 !== e.data || out_valid !== 4'b0100 ||
             xfer_count !== e.cnt) begin
            n_fail++;
            $display("FAIL single_write: dout2=%h ov=%b cnt=%0d want %h 0100 %0d",
                     dout2, out_valid, xfer_count, e.data, e.cnt);
         end
      end
   endtask

   task automatic test_blocked();
      drive(8'h5A, 2'd2, 1'b0, 1'b1, 4'h0, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b0 || dout2 !== 8'hA5 || out_valid !== 4'b0100 ||
          xfer_count !== 8'd1) begin
         n_fail++;
         $display("FAIL blocked: rdy=%b dout2=%h ov=%b cnt=%0d want 0 a5 0100 1",
                  rdy_obs, dout2, out_valid, xfer_count);
      end
      drive(8'h5A, 2'd1, 1'b0, 1'b1, 4'h0, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b1 || sb.size() != 1) begin
         n_fail++;
         $display("FAIL other_slot_ready: got %b want 1", rdy_obs);
      end else begin
         e = sb.pop_front();
         if (dout1 !== e.data || out_valid !== 4'b0110 ||
             xfer_count !== e.cnt) begin
            n_fail++;
            $display("FAIL other_slot: dout1=%h ov=%b cnt=%0d want %h 0110 %0d",
                     dout1, out_valid, xfer_count, e.data, e.cnt);
         end
      end
   endtask

   task automatic test_ack_write();
      drive(8'h11, 2'd0, 1'b0, 1'b1, 4'h0, 1'b0);
      void'(sb.pop_front());
      drive(8'h22, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b1 || sb.size() != 1) begin
         n_fail++;
         $display("FAIL ack_write_ready: got %b want 1", rdy_obs);
      end else begin
         e = sb.pop_front();
         if (dout0 !== 8'h22 || out_valid !== 4'b0111 ||
             xfer_count !== e.cnt) begin
            n_fail++;
            $display("FAIL ack_write: dout0=%h ov=%b cnt=%0d want 22 0111 %0d",
                     dout0, out_valid, xfer_count, e.cnt);
         end
      end
      // Consume slot 1 and ack empty slot 3: only bit 1 drops, data held.
      drive(8'hFF, 2'd3, 1'b1, 1'b0, 4'b1010, 1'b0);
      n_tests++;
      if (out_valid !== 4'b0101 || dout1 !== 8'h5A || dout3 !== 8'h00 ||
          xfer_count !== 8'd4) begin
         n_fail++;
         $display("FAIL ack_only: ov=%b d1=%h d3=%h cnt=%0d want 0101 5a 00 4",
                  out_valid, dout1, dout3, xfer_count);
      end
   endtask

   task automatic test_bcast();
      drive(8'h77, 2'd3, 1'b0, 1'b1, 4'h0, 1'b0);
      void'(sb.pop_front());
      drive(8'h3C, 2'd0, 1'b1, 1'b1, 4'b0101, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b0 || out_valid !== 4'b1000 || dout3 !== 8'h77) begin
         n_fail++;
         $display("FAIL bcast_blocked: rdy=%b ov=%b d3=%h want 0 1000 77",
                  rdy_obs, out_valid, dout3);
      end
      drive(8'h3C, 2'd1, 1'b1, 1'b1, 4'b1000, 1'b0);
      n_tests++;
      if (rdy_obs !== 1'b1 || sb.size() != 1) begin
         n_fail++;
         $display("FAIL bcast_ready: got %b want 1", rdy_obs);
      end else begin
         e = sb.pop_front();
         if (out_valid !== 4'b1111 || xfer_count !== 8'd6 || e.cnt !== 8'd6 ||
             dout0 !== 8'h3C || dout1 !== 8'h3C || dout2 !== 8'h3C ||
             dout3 !== 8'h3C) begin
            n_fail++;
            $display("FAIL bcast: ov=%b cnt=%0d d=%h %h %h %h want 1111 6 3c",
                     out_valid, xfer_count, dout0, dout1, dout2, dout3);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      drive(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
      bad = 0;
      for (int i = 0; i < 257; i++) begin
         drive(8'(i), 2'(i), 1'b0, 1'b1, 4'hF, 1'b0);
         if (rdy_obs !== 1'b1 || sb.size() != 1) begin
            bad++;
         end else begin
            e = sb.pop_front();
            if (dv[i % 4] !== e.data || xfer_count !== e.cnt) bad++;
         end
         if (i == 255) begin
            n_tests++;
            if (xfer_count !== 8'd0) begin
               n_fail++;
               $display("FAIL count_wrap: got %0d want 0", xfer_count);
            end
         end
      end
      n_tests++;
      if (xfer_count !== 8'd1 || bad != 0) begin
         n_fail++;
         $display("FAIL back_to_back: cnt=%0d bad=%0d want 1 0",
                  xfer_count, bad);
      end
   endtask

   task automatic test_reset_priority();
      drive(8'hB1, 2'd1, 1'b0, 1'b1, 4'h0, 1'b0);
      drive(8'hB3, 2'd3, 1'b0, 1'b1, 4'b0001, 1'b0);
      sb.delete();
      n_tests++;
      if (out_valid !== 4'b1010) begin
         n_fail++;
         $display("FAIL prio_setup: ov=%b want 1010", out_valid);
      end
      drive(8'hEE, 2'd0, 1'b0, 1'b1, 4'b0010, 1'b1);
      n_tests++;
      if (out_valid !== 4'b0000 || xfer_count !== 8'd0 || sb.size() != 0 ||
          rdy_obs !== 1'b0 || dout0 !== 8'h00 || dout1 !== 8'h00 ||
          dout2 !== 8'h00 || dout3 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_prio: ov=%b cnt=%0d rdy=%b d=%h %h %h %h want 0",
                  out_valid, xfer_count, rdy_obs, dout0, dout1, dout2, dout3);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         drive(8'($urandom), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), 1'($urandom),
               4'($urandom), ($urandom_range(0, 63) == 0));
         if (rdy_obs !== rdy_exp) bad++;
         if (acc) begin
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
               if (e.mask[k] && (dv[k] !== e.data || out_valid[k] !== 1'b1))
                  bad++;
            end
            if (xfer_count !== e.cnt) bad++;
         end
         if (out_valid !== mv || xfer_count !== mc) bad++;
         for (int k = 0; k < 4; k++) begin
            if (dv[k] !== md[k]) bad++;
         end
      end
      n_tests++;
      if (bad != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL random: %0d cycle errors, %0d left in queue, want 0",
                  bad, sb.size());
      end
   endtask

   initial begin
      reset = 1'b1; din = '0; sel = '0; bcast = 1'b0;
      in_valid = 1'b0; out_ack = '0;
      mv = '0; md = '{default: 8'h00}; mc = '0;
      test_reset();
      test_single();
      test_blocked();
      test_ack_write();
      test_bcast();
      test_back_to_back();
      test_reset_priority();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
